// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants, fetch FSM encoding and the IF/ID payload type.
// Also holds the fetch-address legality rule so every consumer agrees on it.
package cpu_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;
    localparam logic [31:0] IM_LIMIT = IM_BASE + (IM_WORDS << 2);
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } ifid_t;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= IM_BASE) && (a < IM_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: req/addr from fetch, ready/rdata from memory.
// ready may be returned in the same cycle as req.
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: load a new entry, flush to a bubble, or hold.
// One cycle latency; holds its contents whenever neither load nor flush is set.
module ifid_reg
    import cpu_defs::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  logic  flush_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '{valid: 1'b0, instr: NOP, pc: 32'h0, adel: 1'b0};
        end else if (flush_i) begin
            q_q <= '{valid: 1'b0, instr: NOP, pc: d_i.pc, adel: 1'b0};
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem over req/ready and fills IF/ID.
// One instruction per cycle with zero-wait memory; stall holds IF/ID and parks a
// returned word in a skid register; CP0 redirects flush and may drain a pending read.
module fetch_stage
    import cpu_defs::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          pc_load,
    input  logic [31:0]   pc_next,
    input  logic          exc_req,
    input  logic          eret_req,
    input  logic [31:0]   epc,
    fetch_stage_if.master imem,
    output logic          id_valid,
    output logic [31:0]   id_instr,
    output logic [31:0]   id_pc,
    output logic          id_exc_adel
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  skid_q;
    logic         pend_q;
    logic [31:0]  pend_tgt_q;
    logic [31:0]  drain_addr_q;

    logic         pc_legal;
    logic         redirect;
    logic [31:0]  redir_tgt;
    logic [31:0]  adv_tgt;
    logic         advance;
    logic         ifid_load;
    logic         ifid_flush;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    assign pc_legal  = addr_legal(pc_q);
    assign redirect  = exc_req | eret_req;
    assign redir_tgt = exc_req ? EXC_VEC : epc;
    assign adv_tgt   = pc_load ? pc_next : (pend_q ? pend_tgt_q : pc_q + 32'd4);

    // A drain keeps presenting the abandoned address so the bus never sees it change.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        case (state_q)
            ST_FETCH: imem.imem_req = pc_legal;
            ST_DRAIN: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = drain_addr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        advance    = 1'b0;
        ifid_d     = '{valid: 1'b1, instr: NOP, pc: pc_q, adel: 1'b0};
        if (redirect) begin
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!pc_legal) begin
                        if (!stall) begin
                            ifid_load   = 1'b1;
                            ifid_d.adel = 1'b1;
                            advance     = 1'b1;
                        end
                    end else if (imem.imem_ready) begin
                        if (!stall) begin
                            ifid_load    = 1'b1;
                            ifid_d.instr = imem.imem_rdata;
                            advance      = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load    = 1'b1;
                        ifid_d.instr = skid_q;
                        advance      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            skid_q       <= NOP;
            pend_q       <= 1'b0;
            pend_tgt_q   <= 32'h0;
            drain_addr_q <= 32'h0;
        end else if (redirect) begin
            pc_q   <= redir_tgt;
            pend_q <= 1'b0;
            if (state_q == ST_FETCH && pc_legal && !imem.imem_ready) begin
                state_q      <= ST_DRAIN;
                drain_addr_q <= pc_q;
            end else if (state_q == ST_DRAIN && !imem.imem_ready) begin
                state_q <= ST_DRAIN;
            end else begin
                state_q <= ST_FETCH;
            end
        end else begin
            if (advance) begin
                pc_q   <= adv_tgt;
                pend_q <= 1'b0;
            end
            case (state_q)
                ST_FETCH: begin
                    if (pc_legal && imem.imem_ready && stall) begin
                        skid_q  <= imem.imem_rdata;
                        state_q <= ST_HOLD;
                    end else if (pc_legal && !imem.imem_ready && !stall && pc_load) begin
                        // The branch leaves ID this cycle; keep its target until the delay slot lands.
                        pend_q     <= 1'b1;
                        pend_tgt_q <= pc_next;
                    end
                end
                ST_HOLD: begin
                    if (!stall) state_q <= ST_FETCH;
                end
                ST_DRAIN: begin
                    if (imem.imem_ready) state_q <= ST_FETCH;
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    ifid_reg u_ifid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign id_valid    = ifid_q.valid;
    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_exc_adel = ifid_q.adel;

endmodule
